// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: IDLE/RUN/PAUSE/LAP sequencing, 1 Hz prescaler, BCD seconds
// counter with lap hold, and a registered display mux for display_inf.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 125_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_SS,
  input  logic       KEY_LAP,
  output logic [3:0] NUM_1S,
  output logic [2:0] NUM_10S,
  output logic       RUNNING,
  output logic       LAP_ACT,
  output logic       TICK
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t        state, state_n;
  logic [PW-1:0] psc, psc_n;
  logic [3:0]    cnt1, cnt1_n, lap1, lap1_n, disp1_n;
  logic [2:0]    cnt10, cnt10_n, lap10, lap10_n, disp10_n;
  logic          tick_n, wrap;

  assign wrap = (psc == PSC_MAX);

  // Register state, datapath and display; reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      psc     <= '0;
      cnt1    <= '0;
      cnt10   <= '0;
      lap1    <= '0;
      lap10   <= '0;
      NUM_1S  <= '0;
      NUM_10S <= '0;
      TICK    <= 1'b0;
    end else begin
      state   <= state_n;
      psc     <= psc_n;
      cnt1    <= cnt1_n;
      cnt10   <= cnt10_n;
      lap1    <= lap1_n;
      lap10   <= lap10_n;
      NUM_1S  <= disp1_n;
      NUM_10S <= disp10_n;
      TICK    <= tick_n;
    end
  end

  // Next-state, prescaler, count and lap decode; KEY_SS has priority.
  always_comb begin
    state_n = state;
    psc_n   = psc;
    cnt1_n  = cnt1;
    cnt10_n = cnt10;
    lap1_n  = lap1;
    lap10_n = lap10;
    tick_n  = 1'b0;
    case (state)
      IDLE: begin
        if (KEY_SS) begin
          state_n = RUN;
          psc_n   = '0;
        end
      end
      RUN, LAP: begin
        if (wrap) begin
          // A tick coinciding with KEY_SS still lands before the pause.
          psc_n  = '0;
          tick_n = 1'b1;
          if (cnt1 == 4'd9) begin
            cnt1_n  = 4'd0;
            cnt10_n = (cnt10 == 3'd5) ? 3'd0 : cnt10 + 3'd1;
          end else begin
            cnt1_n = cnt1 + 4'd1;
          end
        end else begin
          psc_n = psc + PW'(1);
        end
        if (KEY_SS) begin
          state_n = PAUSE;
          if (!wrap) psc_n = psc;  // hold the phase so resume is seamless
        end else if (KEY_LAP) begin
          if (state == RUN) begin
            state_n = LAP;
            lap1_n  = cnt1;        // pre-increment snapshot
            lap10_n = cnt10;
          end else begin
            state_n = RUN;
          end
        end
      end
      PAUSE: begin
        if (KEY_SS) begin
          state_n = RUN;
        end else if (KEY_LAP) begin
          state_n = IDLE;
          psc_n   = '0;
          cnt1_n  = '0;
          cnt10_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Display follows the next state so it switches on the same edge.
  always_comb begin
    disp1_n  = cnt1_n;
    disp10_n = cnt10_n;
    if (state_n == LAP) begin
      disp1_n  = lap1_n;
      disp10_n = lap10_n;
    end
  end

  assign RUNNING = (state == RUN) || (state == LAP);
  assign LAP_ACT = (state == LAP);

endmodule
